seq_multiplier: RTL and testbench

- Multi-cycle 32x32 to 64-bit integer multiplier.
- It is the responder to the execute stage's multiply request.
- The execute stage holds `enable` high and stalls the pipeline until `done` is seen.
- Supports signed (mult) and unsigned (multu) operands. Uses an iterative shift-add datapath on operand magnitudes, with sign correction at the end.

---
 rtl/seq_multiplier.sv | 118 +++++++++++
 tb/tb_seq_multiplier.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add 32x32->64 multiplier (signed/unsigned) with fixed latency of WIDTH/BITS_PER_CYCLE+1 edges after the request.
// Requester holds enable until done; dropping enable in CALC aborts. Optional early exit: define MUL_EARLY_EXIT_EN.
module seq_multiplier #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 is_unsign,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   result,
    output logic                 done
);

    localparam int ITER = WIDTH / BITS_PER_CYCLE;
    localparam int CW   = $clog2(ITER + 1);
    localparam logic [WIDTH-1:0]   ONE_W  = 1;
    localparam logic [2*WIDTH-1:0] ONE_2W = 1;
    localparam logic [CW-1:0]      ONE_C  = 1;
    localparam logic [CW-1:0]      ITER_C = ITER[CW-1:0];

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state, state_nxt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mreg;
    logic [CW-1:0]        cnt;
    logic                 neg;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   pp;
    logic [2*WIDTH-1:0]   final_val;
    logic                 calc_done;

    // The most negative operand negates to itself, which is its correct unsigned magnitude.
    always_comb begin
        mag_a = (!is_unsign && a[WIDTH-1]) ? (~a + ONE_W) : a;
        mag_b = (!is_unsign && b[WIDTH-1]) ? (~b + ONE_W) : b;
    end

    always_comb begin
        pp = '0;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (mreg[i]) pp = pp + (mcand << i);
        end
    end

    // The multiplicand shifts left instead of the accumulator shifting right,
    // so acc is already aligned whenever the remaining multiplier bits are zero.
`ifdef MUL_EARLY_EXIT_EN
    assign calc_done = (cnt == '0) || (mreg == '0);
`else
    assign calc_done = (cnt == '0);
`endif

    assign final_val = neg ? (~acc + ONE_2W) : acc;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = CALC;
            CALC: begin
                if (!enable)        state_nxt = IDLE;
                else if (calc_done) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            mcand  <= '0;
            mreg   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        mcand <= {{WIDTH{1'b0}}, mag_a};
                        mreg  <= mag_b;
                        neg   <= ~is_unsign & (a[WIDTH-1] ^ b[WIDTH-1]);
                        acc   <= '0;
                        cnt   <= ITER_C;
                    end
                end
                CALC: begin
                    if (enable) begin
                        if (calc_done) begin
                            result <= final_val;
                            done   <= 1'b1;
                        end else begin
                            acc   <= acc + pp;
                            mcand <= mcand << BITS_PER_CYCLE;
                            mreg  <= mreg >> BITS_PER_CYCLE;
                            cnt   <= cnt - ONE_C;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: products, latency, back-to-back, abort, async reset, random vectors.
module tb_seq_multiplier;

    localparam int W   = 32;
    localparam int BPC = 1;

    logic            sys_clk;
    logic            rst_n;
    logic            enable;
    logic            is_unsign;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic [2*W-1:0]  result;
    logic            done;

    int n_vec  = 0;
    int n_fail = 0;

    seq_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .is_unsign (is_unsign),
        .a         (a),
        .b         (b),
        .result    (result),
        .done      (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y, input logic u);
        logic [63:0] ex, ey;
        ex = u ? {32'b0, x} : {{32{x[31]}}, x};
        ey = u ? {32'b0, y} : {{32{y[31]}}, y};
        return ex * ey;
    endfunction

    // Edges after the request edge until done is visible.
    function automatic int exp_lat(input logic [31:0] y, input logic u);
        logic [31:0] mb;
        int msb;
        mb  = (!u && y[31]) ? (~y + 32'd1) : y;
        msb = -1;
        for (int i = 0; i < 32; i++) if (mb[i]) msb = i;
`ifdef MUL_EARLY_EXIT_EN
        if (msb < 0) return 1;
        return msb / BPC + 2;
`else
        return msb * 0 + W / BPC + 1;
`endif
    endfunction

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic tu,
                          output logic [63:0] res, output int lat);
        a = ta; b = tb_v; is_unsign = tu; enable = 1'b1;
        @(posedge sys_clk); #1;
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge sys_clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        res = result;
        enable = 1'b0;
        if (lat > 0) begin
            @(posedge sys_clk); #1;
            check64("done_one_cycle", {63'b0, done}, 64'd0);
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                            input logic tu, input logic [63:0] exp);
        logic [63:0] r;
        int l;
        run_op(ta, tb_v, tu, r, l);
        check64(tag, r, exp);
        check_int({tag, "_lat"}, l, exp_lat(tb_v, tu));
    endtask

    initial begin
        logic [63:0] r1, r2;
        logic [31:0] ra, rb;
        logic        ru;
        int t1, t2, nd, ndone;

        rst_n = 1'b0; enable = 1'b0; is_unsign = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check64("reset_result", result, 64'd0);
        check64("reset_done", {63'b0, done}, 64'd0);
        rst_n = 1'b1;
        @(posedge sys_clk); #1;

        op_check("u_3x5",      32'h0000_0003, 32'h0000_0005, 1'b1, 64'h0000_0000_0000_000F);
        op_check("s_m2x7",     32'hFFFF_FFFE, 32'h0000_0007, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2);
        op_check("u_m2x7",     32'hFFFF_FFFE, 32'h0000_0007, 1'b1, 64'h0000_0006_FFFF_FFF2);
        op_check("s_min_min",  32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000);
        op_check("u_min_min",  32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        op_check("u_max_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFE_0000_0001);
        op_check("s_m1_m1",    32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001);
        op_check("s_m3_m5",    32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b0, 64'h0000_0000_0000_000F);
        op_check("s_5_m1",     32'h0000_0005, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB);
        op_check("u_b_zero",   32'h0000_1234, 32'h0000_0000, 1'b1, 64'h0);

        // Back-to-back: enable stays high through the first DONE cycle.
        a = 32'd7; b = 32'd6; is_unsign = 1'b1; enable = 1'b1;
        @(posedge sys_clk); #1;
        nd = 0; t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge sys_clk); #1;
            if (done) begin
                if (nd == 0) begin
                    t1 = k; r1 = result; a = 32'd9; b = 32'd9;
                end else begin
                    t2 = k; r2 = result;
                end
                nd++;
                if (nd == 2) break;
            end
        end
        enable = 1'b0;
        @(posedge sys_clk); #1;
        check64("b2b_first", r1, 64'd42);
        check64("b2b_second", r2, 64'd81);
        check_int("b2b_ndone", nd, 2);
        check_int("b2b_first_lat", t1, exp_lat(32'd6, 1'b1));
        check_int("b2b_spacing", t2 - t1, exp_lat(32'd9, 1'b1) + 2);

        // Abort: drop enable after 10 CALC edges.
        op_check("pre_abort", 32'd11, 32'd13, 1'b1, 64'd143);
        a = 32'h0000_1234; b = 32'h7FFF_5678; is_unsign = 1'b1; enable = 1'b1;
        @(posedge sys_clk); #1;
        repeat (10) begin @(posedge sys_clk); #1; end
        enable = 1'b0;
        ndone = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge sys_clk); #1;
            if (done) ndone++;
        end
        check_int("abort_no_done", ndone, 0);
        check64("abort_result_kept", result, 64'd143);
        op_check("post_abort", 32'd100, 32'd200, 1'b1, 64'd20000);

        // Asynchronous reset in the middle of CALC.
        a = 32'd5; b = 32'h7FFF_FFFF; is_unsign = 1'b1; enable = 1'b1;
        @(posedge sys_clk); #1;
        repeat (10) begin @(posedge sys_clk); #1; end
        #2;
        rst_n = 1'b0; enable = 1'b0;
        #1;
        check64("rst_mid_result", result, 64'd0);
        check64("rst_mid_done", {63'b0, done}, 64'd0);
        @(posedge sys_clk); #1;
        rst_n = 1'b1;
        @(posedge sys_clk); #1;
        op_check("post_reset", 32'hFFFF_FFFC, 32'd25, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C);

        for (int n = 0; n < 300; n++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            ru = 1'($urandom_range(0, 1));
            op_check("random", ra, rb, ru, ref_mul(ra, rb, ru));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
